// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - MMU page cache tag table and miss refill controller
module cache_refill_ctrl #(
    parameter int NUM_PAGES = 4,
    parameter int TAG_W     = 14,
    parameter int OFS_W     = 10,
    parameter int IDX_W     = 2
) (
    input  logic                   fpgaClk,
    input  logic                   fpgaReset_n,
    input  logic                   lookupValid,
    input  logic [TAG_W-1:0]       lookupTag,
    input  logic                   invalidateAll,
    output logic                   lookupDone,
    output logic                   cacheHit,
    output logic [IDX_W-1:0]       hitIndex,
    output logic                   cpuHold,
    output logic                   extRdReq,
    output logic [TAG_W+OFS_W-1:0] extRdAddr,
    input  logic                   extRdAck,
    input  logic [7:0]             extRdData,
    output logic                   sramWe,
    output logic [IDX_W+OFS_W-1:0] sramAddr,
    output logic [7:0]             sramWdata
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESOLVE = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_UPDATE  = 3'd4;
    localparam logic [OFS_W:0] LAST_OFS = {1'b0, {OFS_W{1'b1}}};

    logic [2:0]           state_q, state_d;
    logic [TAG_W-1:0]     cur_tag_q, cur_tag_d;
    logic [NUM_PAGES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [NUM_PAGES];
    logic [TAG_W-1:0]     tag_d [NUM_PAGES];
    logic [IDX_W-1:0]     victim_ptr_q, victim_ptr_d;
    logic [IDX_W-1:0]     victim_q, victim_d;
    logic                 from_ptr_q, from_ptr_d;
    logic [OFS_W:0]       offset_q, offset_d;
    logic [7:0]           data_q, data_d;
    logic                 inv_pend_q, inv_pend_d;
    logic                 lookup_done_q, lookup_done_d;
    logic                 cache_hit_q, cache_hit_d;
    logic [IDX_W-1:0]     hit_index_q, hit_index_d;

    logic                 hit, any_inv;
    logic [IDX_W-1:0]     hit_idx, inv_idx;

    // Descending scan so the lowest matching / invalid slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        any_inv = 1'b0;
        inv_idx = '0;
        for (int i = NUM_PAGES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == cur_tag_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                any_inv = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_tag_d     = cur_tag_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        victim_ptr_d  = victim_ptr_q;
        victim_d      = victim_q;
        from_ptr_d    = from_ptr_q;
        offset_d      = offset_q;
        data_d        = data_q;
        inv_pend_d    = inv_pend_q;
        lookup_done_d = 1'b0;
        cache_hit_d   = 1'b0;
        hit_index_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (invalidateAll) valid_d = '0;
                if (lookupValid) begin
                    cur_tag_d = lookupTag;
                    state_d   = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (hit) begin
                    lookup_done_d = 1'b1;
                    cache_hit_d   = 1'b1;
                    hit_index_d   = hit_idx;
                    if (invalidateAll || inv_pend_q) valid_d = '0;
                    inv_pend_d    = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    victim_d   = any_inv ? inv_idx : victim_ptr_q;
                    from_ptr_d = !any_inv;
                    offset_d   = '0;
                    inv_pend_d = inv_pend_q || invalidateAll;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                inv_pend_d = inv_pend_q || invalidateAll;
                if (extRdAck) begin
                    data_d  = extRdData;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                inv_pend_d = inv_pend_q || invalidateAll;
                if (offset_q == LAST_OFS) begin
                    state_d = S_UPDATE;
                end else begin
                    offset_d = offset_q + 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_UPDATE: begin
                tag_d[victim_q]   = cur_tag_q;
                valid_d[victim_q] = 1'b1;
                if (from_ptr_q) victim_ptr_d = victim_ptr_q + 1'b1;
                // A pending flush wipes the page just filled as well.
                if (invalidateAll || inv_pend_q) valid_d = '0;
                inv_pend_d    = 1'b0;
                lookup_done_d = 1'b1;
                cache_hit_d   = 1'b1;
                hit_index_d   = victim_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fpgaClk or negedge fpgaReset_n) begin
        if (!fpgaReset_n) begin
            state_q       <= S_IDLE;
            cur_tag_q     <= '0;
            valid_q       <= '0;
            for (int i = 0; i < NUM_PAGES; i++) tag_q[i] <= '0;
            victim_ptr_q  <= '0;
            victim_q      <= '0;
            from_ptr_q    <= 1'b0;
            offset_q      <= '0;
            data_q        <= '0;
            inv_pend_q    <= 1'b0;
            lookup_done_q <= 1'b0;
            cache_hit_q   <= 1'b0;
            hit_index_q   <= '0;
        end else begin
            state_q       <= state_d;
            cur_tag_q     <= cur_tag_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            victim_ptr_q  <= victim_ptr_d;
            victim_q      <= victim_d;
            from_ptr_q    <= from_ptr_d;
            offset_q      <= offset_d;
            data_q        <= data_d;
            inv_pend_q    <= inv_pend_d;
            lookup_done_q <= lookup_done_d;
            cache_hit_q   <= cache_hit_d;
            hit_index_q   <= hit_index_d;
        end
    end

    // Port strobes decode straight from state so reset removes them at once.
    assign lookupDone = lookup_done_q;
    assign cacheHit   = cache_hit_q;
    assign hitIndex   = hit_index_q;
    assign cpuHold    = (state_q == S_FETCH) || (state_q == S_WRITE) || (state_q == S_UPDATE);
    assign extRdReq   = (state_q == S_FETCH);
    assign extRdAddr  = extRdReq ? {cur_tag_q, offset_q[OFS_W-1:0]} : '0;
    assign sramWe     = (state_q == S_WRITE);
    assign sramAddr   = sramWe ? {victim_q, offset_q[OFS_W-1:0]} : '0;
    assign sramWdata  = sramWe ? data_q : '0;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;
    logic        fpgaClk = 1'b0;
    logic        fpgaReset_n;
    logic        lookupValid;
    logic [13:0] lookupTag;
    logic        invalidateAll;
    logic        lookupDone;
    logic        cacheHit;
    logic [1:0]  hitIndex;
    logic        cpuHold;
    logic        extRdReq;
    logic [15:0] extRdAddr;
    logic        extRdAck;
    logic [7:0]  extRdData;
    logic        sramWe;
    logic [3:0]  sramAddr;
    logic [7:0]  sramWdata;

    int compared   = 0;
    int mismatched = 0;

    logic [13:0] m_tag [4];
    logic [3:0]  m_valid;
    int          m_ptr;

    always #5 fpgaClk = ~fpgaClk;

    cache_refill_ctrl #(.NUM_PAGES(4), .TAG_W(14), .OFS_W(2), .IDX_W(2)) dut (
        .fpgaClk(fpgaClk), .fpgaReset_n(fpgaReset_n),
        .lookupValid(lookupValid), .lookupTag(lookupTag), .invalidateAll(invalidateAll),
        .lookupDone(lookupDone), .cacheHit(cacheHit), .hitIndex(hitIndex), .cpuHold(cpuHold),
        .extRdReq(extRdReq), .extRdAddr(extRdAddr), .extRdAck(extRdAck), .extRdData(extRdData),
        .sramWe(sramWe), .sramAddr(sramAddr), .sramWdata(sramWdata)
    );

    function automatic logic [7:0] mem(input logic [15:0] a);
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) m_tag[i] = '0;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_done"}, lookupDone, 0);
        chk({name, "_hit"}, cacheHit, 0);
        chk({name, "_idx"}, hitIndex, 0);
        chk({name, "_hold"}, cpuHold, 0);
        chk({name, "_req"}, extRdReq, 0);
        chk({name, "_raddr"}, extRdAddr, 0);
        chk({name, "_we"}, sramWe, 0);
        chk({name, "_saddr"}, sramAddr, 0);
        chk({name, "_wdata"}, sramWdata, 0);
    endtask

    // One lookup from IDLE through to lookupDone, acting as backing memory.
    task automatic lookup(input logic [13:0] tag, input bit inv_same, input int inv_write,
                          input int slow_ofs, input int rst_write);
        bit exp_hit, from_ptr, done, pending;
        int exp_idx, exp_cycles, done_cyc, ofs, wait_c, dly, writes;
        logic [1:0] o;
        if (inv_same) m_valid = '0;
        exp_hit = 0;
        exp_idx = -1;
        for (int i = 3; i >= 0; i--)
            if (m_valid[i] && m_tag[i] == tag) begin exp_hit = 1; exp_idx = i; end
        from_ptr = 0;
        if (!exp_hit) begin
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) exp_idx = i;
            if (exp_idx < 0) begin from_ptr = 1; exp_idx = m_ptr; end
        end
        @(negedge fpgaClk);
        lookupValid = 1'b1; lookupTag = tag; invalidateAll = inv_same;
        @(negedge fpgaClk);
        lookupValid = 1'b0; invalidateAll = 1'b0;
        chk("resolve_hold", cpuHold, 0);
        chk("resolve_done", lookupDone, 0);
        ofs = 0; wait_c = 0; writes = 0; pending = 0; done = 0; done_cyc = 0;
        dly = (slow_ofs == 0) ? 5 : $urandom_range(0, 2);
        exp_cycles = exp_hit ? 1 : 2;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge fpgaClk);
            extRdAck = 1'b0; invalidateAll = 1'b0;
            assert (!(lookupValid && cpuHold)) else begin
                mismatched++;
                $error("FAIL protocol_lookup_in_hold: observed 1 expected 0");
            end
            o = ofs[1:0];
            if (lookupDone) begin
                done = 1; done_cyc = cyc;
                chk("done_hit", cacheHit, 1);
                chk("done_index", hitIndex, exp_idx);
                chk("done_hold", cpuHold, 0);
            end else if (!exp_hit) begin
                chk("refill_hold", cpuHold, 1);
                if (extRdReq) begin
                    chk("fetch_addr", extRdAddr, {tag, o});
                    chk("fetch_no_we", sramWe, 0);
                    if (wait_c == dly) begin
                        extRdAck = 1'b1; extRdData = mem({tag, o});
                    end else wait_c++;
                end else if (sramWe) begin
                    chk("write_addr", sramAddr, {exp_idx[1:0], o});
                    chk("write_data", sramWdata, mem({tag, o}));
                    exp_cycles += dly + 2;
                    if (writes == rst_write) begin
                        fpgaReset_n = 1'b0;
                        #1;
                        chk_outputs_zero("midreset");
                        model_reset();
                        repeat (2) @(negedge fpgaClk);
                        fpgaReset_n = 1'b1;
                        return;
                    end
                    if (writes == inv_write) begin invalidateAll = 1'b1; pending = 1; end
                    writes++; ofs++; wait_c = 0;
                    dly = (ofs == slow_ofs) ? 5 : $urandom_range(0, 2);
                end
            end
        end
        chk("done_seen", done, 1);
        chk("done_latency", done_cyc, exp_cycles);
        if (!exp_hit) chk("write_count", writes, 4);
        extRdAck = 1'b0; invalidateAll = 1'b0;
        if (!exp_hit) begin
            m_tag[exp_idx] = tag;
            m_valid[exp_idx] = 1'b1;
            if (from_ptr) m_ptr = (m_ptr + 1) % 4;
            if (pending) m_valid = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge fpgaClk);
        fpgaReset_n = 1'b0;
        #1;
        chk_outputs_zero("reset");
        model_reset();
        @(negedge fpgaClk);
        fpgaReset_n = 1'b1;
    endtask

    initial begin
        fpgaReset_n = 1'b0; lookupValid = 1'b0; lookupTag = '0; invalidateAll = 1'b0;
        extRdAck = 1'b0; extRdData = '0;
        model_reset();
        repeat (3) @(negedge fpgaClk);
        chk_outputs_zero("por");
        fpgaReset_n = 1'b1;

        lookup(14'h0002, 0, -1, -1, -1);
        lookup(14'h0002, 0, -1, -1, -1);

        do_reset();
        for (int t = 0; t < 4; t++) lookup(14'h0010 + 14'(t), 0, -1, -1, -1);
        lookup(14'h0014, 0, -1, -1, -1);
        lookup(14'h0015, 0, -1, -1, -1);
        lookup(14'h0010, 0, -1, -1, -1);

        lookup(14'h0020, 0, -1, 1, -1);

        do_reset();
        lookup(14'h0030, 0, 1, -1, -1);
        lookup(14'h0030, 0, -1, -1, -1);
        lookup(14'h0030, 1, -1, -1, -1);

        lookup(14'h0040, 0, -1, -1, 2);
        lookup(14'h0040, 0, -1, -1, -1);

        for (int n = 0; n < 24; n++)
            lookup(14'h0050 + 14'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
